// File: rtl/exp7_exibe_sequencia.sv
// exp7_exibe_sequencia
// Plays the stored color sequence back on the LEDs before each round of the
// memory game. On iniciar it walks addresses 0..rodada, lighting each entry
// for ON_CICLOS cycles and blanking for OFF_CICLOS cycles, then pulses pronto.
// Optional feature macro: EXIBE_ABORTA_EN (enables the abortar input).
//
// state   | meaning
// --------+--------------------------------------------------------------
// OCIOSO  | idle, waits for iniciar; endereco keeps last shown address
// CARREGA | latch rodada, clear address and counter
// ACENDE  | LEDs show dado_memoria for ON_CICLOS cycles
// APAGA   | LEDs blank for OFF_CICLOS cycles, then FIM or PROXIMO
// PROXIMO | advance address, one extra blank cycle
// FIM     | one-cycle pronto pulse
module exp7_exibe_sequencia #(
  parameter int ON_CICLOS  = 1000,
  parameter int OFF_CICLOS = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int MAX_CICLOS = (ON_CICLOS > OFF_CICLOS) ? ON_CICLOS : OFF_CICLOS;
  localparam int CW         = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;
  localparam logic [CW-1:0] ON_FIM  = CW'(ON_CICLOS - 1);
  localparam logic [CW-1:0] OFF_FIM = CW'(OFF_CICLOS - 1);
  localparam logic [CW-1:0] UM      = CW'(1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t       estado;
  estado_t       estado_prox;
  logic [CW-1:0] contagem;
  logic [3:0]    rodada_reg;
  logic          fim_on;
  logic          fim_off;
  logic          ultimo;
  logic          aborta;

  assign fim_on  = (contagem == ON_FIM);
  assign fim_off = (contagem == OFF_FIM);
  assign ultimo  = (endereco == rodada_reg);

`ifdef EXIBE_ABORTA_EN
  assign aborta = abortar && (estado != OCIOSO);
`else
  // abortar is kept on the port list for pin compatibility only
  logic abortar_unused;
  assign abortar_unused = abortar;
  assign aborta         = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // address, latched round length and timer; frozen on abort so endereco holds
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco   <= 4'd0;
      rodada_reg <= 4'd0;
      contagem   <= '0;
    end else if (!aborta) begin
      case (estado)
        CARREGA: begin
          rodada_reg <= rodada;
          endereco   <= 4'd0;
          contagem   <= '0;
        end
        ACENDE:  contagem <= fim_on  ? '0 : contagem + UM;
        APAGA:   contagem <= fim_off ? '0 : contagem + UM;
        PROXIMO: begin
          endereco <= endereco + 4'd1;
          contagem <= '0;
        end
        default: ;
      endcase
    end
  end

  // next state and Moore outputs
  always_comb begin
    estado_prox = estado;
    leds        = 4'd0;
    exibindo    = 1'b0;
    pronto      = 1'b0;
    db_estado   = 4'hF;
    case (estado)
      OCIOSO: begin
        db_estado = 4'd0;
        if (iniciar) estado_prox = CARREGA;
      end
      CARREGA: begin
        db_estado   = 4'd1;
        exibindo    = 1'b1;
        estado_prox = ACENDE;
      end
      ACENDE: begin
        db_estado = 4'd2;
        exibindo  = 1'b1;
        leds      = dado_memoria;
        if (fim_on) estado_prox = APAGA;
      end
      APAGA: begin
        db_estado = 4'd3;
        exibindo  = 1'b1;
        if (fim_off) estado_prox = ultimo ? FIM : PROXIMO;
      end
      PROXIMO: begin
        db_estado   = 4'd4;
        exibindo    = 1'b1;
        estado_prox = ACENDE;
      end
      FIM: begin
        db_estado   = 4'd5;
        pronto      = 1'b1;
        estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
    if (aborta) estado_prox = OCIOSO;
  end

endmodule

// File: tb/tb_exp7_exibe_sequencia.sv
// Bench for exp7_exibe_sequencia: a cycle-offset timeline model of one display
// run is checked against the DUT every cycle, plus directed literal checks.
module tb_exp7_exibe_sequencia;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = ON + OFF + 1;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic [3:0] rodada  = 4'd0;
  logic [3:0] mem [16];
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;

  // model: run active, cycle offset c after the sampling edge, entry count n
  int         m_active = 0;
  int         m_c      = 0;
  int         m_n      = 1;
  logic [3:0] m_end    = 4'd0;

  logic [3:0] cap_leds [0:127];
  logic       cap_pr   [0:127];
  logic [3:0] cap_st   [0:127];
  logic [3:0] cap_en   [0:127];

  exp7_exibe_sequencia #(.ON_CICLOS(ON), .OFF_CICLOS(OFF)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .rodada       (rodada),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .exibindo     (exibindo),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  assign dado_memoria = mem[endereco];

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // expected outputs for the current cycle, from the run timeline
  task automatic model_exp(output logic [3:0] st, output logic [3:0] lds,
                           output logic [3:0] en, output logic ex, output logic pr);
    int t, u, i, r;
    st = 4'd0; lds = 4'd0; en = m_end; ex = 1'b0; pr = 1'b0;
    if (m_active != 0) begin
      t = m_n * (ON + OFF) + m_n + 1;
      if (m_c == 1) begin
        st = 4'd1; ex = 1'b1;
      end else if (m_c == t) begin
        st = 4'd5; pr = 1'b1; en = 4'(m_n - 1);
      end else begin
        u = m_c - 2; i = u / P; r = u % P;
        en = 4'(i); ex = 1'b1;
        if (r < ON) begin
          st = 4'd2; lds = mem[i];
        end else if (r < ON + OFF) begin
          st = 4'd3;
        end else begin
          st = 4'd4;
        end
      end
    end
  endtask

  // model advance on each clock edge
  always @(posedge clock or negedge reset) begin : model_upd
    logic [3:0] s, l, e;
    logic x, p;
    int t;
    if (!reset) begin
      m_active = 0; m_c = 0; m_n = 1; m_end = 4'd0;
    end else if (m_active != 0) begin
      model_exp(s, l, e, x, p);
`ifdef EXIBE_ABORTA_EN
      if (abortar) begin
        m_end = e; m_active = 0;
      end else begin
`else
      begin
`endif
        if (m_c == 1) begin
          m_n = int'(rodada) + 1; m_end = 4'd0;
        end
        t = m_n * (ON + OFF) + m_n + 1;
        if (m_c == t) begin
          m_active = 0; m_end = 4'(m_n - 1);
        end else begin
          m_c++;
        end
      end
    end else if (iniciar) begin
      m_active = 1; m_c = 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clock) begin : compare
    logic [3:0] s, l, e;
    logic x, p;
    if (reset) begin
      model_exp(s, l, e, x, p);
      chk("db_estado", db_estado, s);
      chk("leds", leds, l);
      chk("endereco", endereco, e);
      chk("exibindo", exibindo, x);
      chk("pronto", pronto, p);
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (m_active != 0 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) chk("wait_idle_timeout", 1, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic run_capture(input int ncyc, input int inj_at, input logic [3:0] inj_rod,
                             input logic inj_ini, input logic inj_ab);
    @(negedge clock);
    iniciar = 1'b1;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clock);
      cap_leds[j] = leds; cap_pr[j] = pronto; cap_st[j] = db_estado; cap_en[j] = endereco;
      iniciar = 1'b0;
      abortar = 1'b0;
      if (j == inj_at) begin
        rodada = inj_rod; iniciar = inj_ini; abortar = inj_ab;
      end
    end
  endtask

  function automatic int count_pronto(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (cap_pr[j]) n++;
    return n;
  endfunction

  initial begin
    int intervals, drops;
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << $urandom_range(0, 3));
    repeat (2) @(negedge clock);
    #1;
    chk("reset_db_estado", db_estado, 0);
    chk("reset_leds", leds, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single entry
    mem[0] = 4'b0100; rodada = 4'd0;
    run_capture(10, 0, 4'd0, 1'b0, 1'b0);
    chk("single_carrega", cap_st[1], 1);
    chk("single_leds_k1", cap_leds[1], 0);
    for (int j = 2; j <= 4; j++) chk("single_lit", cap_leds[j], 4'b0100);
    chk("single_gap5", cap_leds[5], 0);
    chk("single_gap6", cap_leds[6], 0);
    chk("single_pronto_k7", cap_pr[7], 1);
    chk("single_pronto_count", count_pronto(1, 10), 1);
    wait_idle();

    // two entries
    mem[0] = 4'b0001; mem[1] = 4'b1000; rodada = 4'd1;
    run_capture(16, 0, 4'd0, 1'b0, 1'b0);
    chk("two_lit0_k2", cap_leds[2], 4'b0001);
    chk("two_lit0_k4", cap_leds[4], 4'b0001);
    for (int j = 5; j <= 7; j++) chk("two_gap", cap_leds[j], 0);
    chk("two_lit1_k8", cap_leds[8], 4'b1000);
    chk("two_lit1_k10", cap_leds[10], 4'b1000);
    chk("two_gap_k11", cap_leds[11], 0);
    chk("two_pronto_k13", cap_pr[13], 1);
    chk("two_pronto_count", count_pronto(1, 16), 1);
    chk("two_endereco_end", cap_en[15], 1);
    wait_idle();

    // full sequence
    rodada = 4'd15;
    run_capture(100, 0, 4'd0, 1'b0, 1'b0);
    intervals = 0; drops = 0;
    for (int j = 2; j <= 100; j++) begin
      if (cap_leds[j] != 0 && cap_leds[j-1] == 0) intervals++;
      if (j > 2 && j <= 97 && cap_en[j] < cap_en[j-1]) drops++;
    end
    chk("full_intervals", intervals, 16);
    chk("full_no_wrap", drops, 0);
    chk("full_pronto_k97", cap_pr[97], 1);
    chk("full_pronto_count", count_pronto(1, 100), 1);
    chk("full_endereco_end", cap_en[99], 15);
    wait_idle();

    // rodada change and iniciar during acende are ignored
    mem[0] = 4'b0010; rodada = 4'd0;
    run_capture(12, 3, 4'd5, 1'b1, 1'b0);
    chk("ign_pronto_k7", cap_pr[7], 1);
    chk("ign_pronto_count", count_pronto(1, 12), 1);
    chk("ign_idle_k8", cap_st[8], 0);
    chk("ign_idle_k10", cap_st[10], 0);
    wait_idle();

    // abort in second cycle of acende
    mem[0] = 4'b1000; rodada = 4'd0;
    run_capture(24, 3, 4'd0, 1'b0, 1'b1);
`ifdef EXIBE_ABORTA_EN
    chk("abort_state_k4", cap_st[4], 0);
    chk("abort_leds_k4", cap_leds[4], 0);
    chk("abort_pronto_count", count_pronto(1, 24), 0);
`else
    chk("noabort_state_k4", cap_st[4], 2);
    chk("noabort_leds_k4", cap_leds[4], 4'b1000);
    chk("noabort_pronto_count", count_pronto(1, 24), 1);
`endif
    wait_idle();

    // asynchronous reset in the middle of a run
    rodada = 4'd3;
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    repeat (9) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("arst_db_estado", db_estado, 0);
    chk("arst_leds", leds, 0);
    chk("arst_exibindo", exibindo, 0);
    chk("arst_pronto", pronto, 0);
    chk("arst_endereco", endereco, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1 chk("arst_release_idle", db_estado, 0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      iniciar = ($urandom_range(0, 5) == 0);
      rodada  = 4'($urandom);
      abortar = ($urandom_range(0, 59) == 0);
      if (m_active == 0) mem[$urandom_range(0, 15)] = 4'(1 << $urandom_range(0, 3));
    end
    iniciar = 1'b0; abortar = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
